// File: rtl/us_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// us_pkg : constants shared by the ranger instances and sensor processing
// Rev 1.0
// ------------------------------------------------------------------
package us_pkg;

   localparam int unsigned DIST_W = 8;
   localparam logic [DIST_W-1:0] MAX_DIST = 8'd255;

   localparam int unsigned CNT_W = 21;
   localparam int unsigned SUB_W = 13;

   localparam int unsigned DEF_TRIG_CYCLES     = 500;
   localparam int unsigned DEF_HOLDOFF_CYCLES  = 75000;
   localparam int unsigned DEF_CYC_PER_CM      = 5800;
   localparam int unsigned DEF_TIMEOUT_CYCLES  = 2000000;
   localparam int unsigned DEF_COOLDOWN_CYCLES = 500000;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] PRE_LOW   = 3'd1;
   localparam logic [2:0] TRIG      = 3'd2;
   localparam logic [2:0] POST_LOW  = 3'd3;
   localparam logic [2:0] HOLDOFF   = 3'd4;
   localparam logic [2:0] WAIT_RISE = 3'd5;
   localparam logic [2:0] MEASURE   = 3'd6;
   localparam logic [2:0] COOLDOWN  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/us_median3.sv
`default_nettype none
// ------------------------------------------------------------------
// us_median3 : combinational median of three distances
// Rev 1.0
// ------------------------------------------------------------------
module us_median3
   import us_pkg::*;
(
   input  logic [DIST_W-1:0] a_i,
   input  logic [DIST_W-1:0] b_i,
   input  logic [DIST_W-1:0] c_i,
   output logic [DIST_W-1:0] med_o
);

   logic ab_ge;
   logic ac_ge;
   logic bc_ge;

   assign ab_ge = (a_i >= b_i);
   assign ac_ge = (a_i >= c_i);
   assign bc_ge = (b_i >= c_i);

   // a lies between b and c when it compares differently against each
   always_comb begin
      if (ab_ge ^ ac_ge)
         med_o = a_i;
      else if (ab_ge == bc_ge)
         med_o = b_i;
      else
         med_o = c_i;
   end

endmodule
`default_nettype wire

// File: rtl/us_ping_ranger.sv
`default_nettype none
// ------------------------------------------------------------------
// us_ping_ranger : single-pin ultrasonic ranger with median-of-3 filter
// Rev 1.0
// ------------------------------------------------------------------
module us_ping_ranger
   import us_pkg::*;
#(
   parameter int unsigned       TRIG_CYCLES     = DEF_TRIG_CYCLES,
   parameter int unsigned       HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
   parameter int unsigned       CYC_PER_CM      = DEF_CYC_PER_CM,
   parameter int unsigned       TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
   parameter int unsigned       COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter logic [DIST_W-1:0] MAX_DIST        = us_pkg::MAX_DIST
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   inout  wire               sig_io,
   output logic [DIST_W-1:0] distance_raw_o,
   output logic [DIST_W-1:0] distance_debounced_o,
   output logic              valid_o,
   output logic              no_echo_o,
   output logic              busy_o
);

   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYC_PER_CM - 1);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SUB_W-1:0]  sub_q, sub_d;
   logic [DIST_W-1:0] cm_q, cm_d;
   logic              busy_q, busy_d;
   logic [1:0]        sync_q;
   logic [DIST_W-1:0] raw_q, med_q, hist0_q, hist1_q;
   logic              valid_q, no_echo_q;

   logic              echo;
   logic              done;
   logic [DIST_W-1:0] result;
   logic              result_ne;
   logic [DIST_W-1:0] med;
   logic              drive_en;
   logic              drive_val;

   assign echo = sync_q[1];

   assign drive_en  = (state_q == PRE_LOW) || (state_q == TRIG) || (state_q == POST_LOW);
   assign drive_val = (state_q == TRIG);
   assign sig_io    = drive_en ? drive_val : 1'bz;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      sub_d     = sub_q;
      cm_d      = cm_q;
      busy_d    = busy_q;
      done      = 1'b0;
      result    = '0;
      result_ne = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_i) begin
               state_d = PRE_LOW;
               busy_d  = 1'b1;
            end
         end
         PRE_LOW: begin
            cnt_d   = '0;
            state_d = TRIG;
         end
         TRIG: begin
            if (cnt_q == TRIG_LAST) begin
               cnt_d   = '0;
               state_d = POST_LOW;
            end
         end
         POST_LOW: begin
            cnt_d   = '0;
            state_d = HOLDOFF;
         end
         HOLDOFF: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_RISE;
            end
         end
         WAIT_RISE: begin
            if (echo) begin
               cnt_d   = '0;
               sub_d   = '0;
               cm_d    = '0;
               state_d = MEASURE;
            end else if (cnt_q == TO_LAST) begin
               cnt_d     = '0;
               done      = 1'b1;
               result    = MAX_DIST;
               result_ne = 1'b1;
               state_d   = COOLDOWN;
            end
         end
         MEASURE: begin
            if (!echo) begin
               cnt_d   = '0;
               done    = 1'b1;
               result  = cm_q;
               state_d = COOLDOWN;
            end else if (cnt_q == TO_LAST) begin
               cnt_d     = '0;
               done      = 1'b1;
               result    = MAX_DIST;
               result_ne = 1'b1;
               state_d   = COOLDOWN;
            end else if (sub_q == SUB_LAST) begin
               sub_d = '0;
               if (cm_q != MAX_DIST)
                  cm_d = cm_q + 1'b1;
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end
         COOLDOWN: begin
            if (cnt_q == COOL_LAST) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // The new result is filtered against the two previous ones in the same cycle
   us_median3 u_median3 (
      .a_i   (result),
      .b_i   (hist0_q),
      .c_i   (hist1_q),
      .med_o (med)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sub_q     <= '0;
         cm_q      <= '0;
         busy_q    <= 1'b0;
         sync_q    <= '0;
         raw_q     <= '0;
         med_q     <= '0;
         hist0_q   <= '0;
         hist1_q   <= '0;
         valid_q   <= 1'b0;
         no_echo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sub_q   <= sub_d;
         cm_q    <= cm_d;
         busy_q  <= busy_d;
         sync_q  <= {sync_q[0], sig_io};
         valid_q <= done;
         if (done) begin
            raw_q     <= result;
            med_q     <= med;
            no_echo_q <= result_ne;
            hist0_q   <= result;
            hist1_q   <= hist0_q;
         end
      end
   end

   assign distance_raw_o       = raw_q;
   assign distance_debounced_o = med_q;
   assign valid_o              = valid_q;
   assign no_echo_o            = no_echo_q;
   assign busy_o               = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_us_ping_ranger.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_us_ping_ranger : scoreboard bench with a PING sensor model on the pin
// Rev 1.0
// ------------------------------------------------------------------
module tb_us_ping_ranger;
   import us_pkg::*;

   localparam int unsigned TRIG = 5;
   localparam int unsigned HOLD = 10;
   localparam int unsigned CPC  = 10;
   localparam int unsigned TO   = 3000;
   localparam int unsigned COOL = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       echo_en = 1'b0;
   wire        sig;
   logic [7:0] dist_raw, dist_deb;
   logic       valid, no_echo, busy;

   assign sig = echo_en ? 1'b1 : 1'bz;
   pulldown (sig);

   us_ping_ranger #(
      .TRIG_CYCLES     (TRIG),
      .HOLDOFF_CYCLES  (HOLD),
      .CYC_PER_CM      (CPC),
      .TIMEOUT_CYCLES  (TO),
      .COOLDOWN_CYCLES (COOL),
      .MAX_DIST        (8'd255)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .start_i              (start),
      .sig_io               (sig),
      .distance_raw_o       (dist_raw),
      .distance_debounced_o (dist_deb),
      .valid_o              (valid),
      .no_echo_o            (no_echo),
      .busy_o               (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] raw;
      logic [7:0] med;
      logic       ne;
   } exp_t;

   exp_t exp_q[$];
   int compared = 0, mismatched = 0;
   int cyc = 0;
   int triggers = 0, valids = 0, busy_rises = 0, aborted = 0;
   int last_valid_cyc = 0, trig_fall_cyc = 0;
   int cur_delay = 30, cur_width = 0, cur_glitch = 0;
   int h0 = 0, h1 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int median3(input int a, input int b, input int c);
      int s[$];
      s = '{a, b, c};
      s.sort();
      return s[1];
   endfunction

   // Reference: distance = echo width / cycles-per-cm, clamped; timeout -> 255 with NO_ECHO
   task automatic predict();
      int r, m;
      bit ne;
      exp_t e;
      if (cur_width == 0) begin
         r = 255; ne = 1'b1;
      end else begin
         r = cur_width / CPC; ne = 1'b0;
         if (r > 255) r = 255;
      end
      m  = median3(r, h0, h1);
      h1 = h0;
      h0 = r;
      e.raw = 8'(r); e.med = 8'(m); e.ne = ne;
      exp_q.push_back(e);
   endtask

   // Sensor: after the trigger's falling edge, optional holdoff glitch, then echo
   initial begin : sensor
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && prev && !sig && !echo_en) begin
            triggers++;
            trig_fall_cyc = cyc;
            predict();
            if (cur_glitch != 0) begin
               repeat (3) @(negedge clk);
               echo_en = 1'b1;
               repeat (3) @(negedge clk);
               echo_en = 1'b0;
               repeat (cur_delay - 5) @(negedge clk);
            end else begin
               repeat (cur_delay + 1) @(negedge clk);
            end
            if (cur_width > 0) begin
               echo_en = 1'b1;
               repeat (cur_width) @(negedge clk);
               echo_en = 1'b0;
            end
            prev = 1'b0;
         end else begin
            prev = sig;
         end
      end
   end

   initial begin : monitor
      logic pb;
      exp_t e;
      pb = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && busy && !pb) busy_rises++;
         pb = busy;
         if (valid) begin
            valids++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("raw", int'(dist_raw), int'(e.raw));
               check("debounced", int'(dist_deb), int'(e.med));
               check("no_echo", int'(no_echo), int'(e.ne));
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 8000) begin
         @(negedge clk);
         n++;
      end
      if (busy) check(name, 1, 0);
   endtask

   task automatic run(input int delay, input int width, input int glitch, input bit capture);
      int v0, ones, first, busy_ok;
      cur_delay = delay; cur_width = width; cur_glitch = glitch;
      v0 = valids;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (capture) begin
         ones = 0; first = -1; busy_ok = 1;
         for (int i = 0; i < 9; i++) begin
            if (sig) begin
               ones++;
               if (first < 0) first = i;
            end
            if (!busy) busy_ok = 0;
            if (i < 8) @(negedge clk);
         end
         check("trig_high_cycles", ones, TRIG);
         check("trig_pre_low", first, 1);
         check("trig_busy", busy_ok, 1);
      end
      wait_idle("busy_stuck");
      check("valid_count", valids - v0, 1);
      if (valids - v0 == 1) check("cooldown_len", cyc - last_valid_cyc, COOL);
   endtask

   initial begin : stim
      int v0, t0, n;
      repeat (3) @(negedge clk);
      check("rst_raw", int'(dist_raw), 0);
      check("rst_deb", int'(dist_deb), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_no_echo", int'(no_echo), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;

      run(30, 405, 0, 1'b1);
      run(25, 2005, 0, 1'b0);
      run(40, 425, 0, 1'b0);
      run(30, 1005, 0, 1'b0);
      run(20, 2905, 0, 1'b0);
      run(20, 0, 0, 1'b0);
      check("timeout_latency", last_valid_cyc - trig_fall_cyc, 1 + HOLD + TO);
      run(30, 505, 1, 1'b0);

      cur_delay = 20; cur_width = 305; cur_glitch = 0;
      v0 = valids; t0 = triggers; n = 0;
      @(negedge clk);
      start = 1'b1;
      while (valids - v0 < 2 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      wait_idle("busy_stuck_held");
      check("held_start_meas", triggers - t0, 2);

      cur_delay = 20; cur_width = 800; cur_glitch = 0;
      v0 = valids;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (250) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_raw", int'(dist_raw), 0);
      check("abort_deb", int'(dist_deb), 0);
      check("abort_no_echo", int'(no_echo), 0);
      check("abort_valid", int'(valid), 0);
      exp_q.delete();
      aborted++;
      h0 = 0; h1 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (700) @(negedge clk);
      check("abort_no_valid", valids - v0, 0);

      run(25, 125, 0, 1'b0);
      for (int k = 0; k < 6; k++)
         run(int'($urandom_range(15, 60)), int'($urandom_range(0, 295)) * 10 + 5,
             int'($urandom_range(0, 1)), 1'b0);

      check("busy_rises_vs_triggers", busy_rises, triggers);
      check("valids_vs_triggers", valids + aborted, triggers);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/us_ping_ranger.md
Name: us_ping_ranger

Overview:
- Drives one single-wire ultrasonic ranging sensor (PING-style): trigger pulse out, echo pulse back on the same pin.
- Measures echo width, converts it to an 8-bit distance in cm and median-of-3 filters it.
- Presents a registered distance to the sensor-processing and direction-control stages.
- One instance per sensor pin (front, back, side-front, side-back); the instances are started in staggered order by the sensor-processing stage to avoid crosstalk.

Parameters:
- TRIG_CYCLES, 500, trigger high time in CLK cycles (5 us at 100 MHz).
- HOLDOFF_CYCLES, 75000, pin released and echo ignored after trigger (750 us).
- CYC_PER_CM, 5800, CLK cycles of echo per cm (58 us round trip).
- TIMEOUT_CYCLES, 2000000, max wait for echo rise, and max echo width (20 ms).
- COOLDOWN_CYCLES, 500000, quiet time after each measurement before BUSY drops (5 ms).
- MAX_DIST, 255, saturation/no-echo distance value.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST_N  input  1  synchronous reset, active-low.
- START  input  1  single-cycle request; sampled only in IDLE.
- SIG  inout  1  sensor pin: driven 1 during TRIG, 0 for one cycle before and after TRIG, high-Z otherwise.
- DISTANCE_RAW  output  8  last unfiltered distance in cm.
- DISTANCE_DEBOUNCED  output  8  median of last 3 raw results.
- VALID  output  1  one-cycle pulse when both distance outputs update.
- NO_ECHO  output  1  set with VALID when the result was a timeout; cleared on the next VALID.
- BUSY  output  1  high from START acceptance until return to IDLE.

Behaviour:
- Reset (RST_N=0 at posedge CLK):
  - FSM goes to IDLE; all counters clear; SIG is high-Z.
  - DISTANCE_RAW=0, DISTANCE_DEBOUNCED=0, VALID=0, NO_ECHO=0, BUSY=0.
  - Median history is cleared to 0.
  - Reset mid-operation aborts immediately, releases the pin and emits no VALID.
- Echo input: SIG passes through a 2-flop synchroniser before use, adding 2 cycles of latency. The width error this introduces is below 1 cm and is accepted.
- FSM states:
  - IDLE: START=1 -> PRE_LOW, BUSY=1 on the next cycle.
  - PRE_LOW: drive 0 for 1 cycle -> TRIG.
  - TRIG: drive 1 for TRIG_CYCLES -> POST_LOW.
  - POST_LOW: drive 0 for 1 cycle, then release -> HOLDOFF.
  - HOLDOFF: wait HOLDOFF_CYCLES and ignore the synchronised echo -> WAIT_RISE.
  - WAIT_RISE: synchronised echo=1 -> MEASURE, clearing the cm counter and sub-counter.
    - If TIMEOUT_CYCLES elapse first: RAW=MAX_DIST, NO_ECHO=1, VALID -> COOLDOWN.
  - MEASURE: sub-counter counts 0..CYC_PER_CM-1; on wrap, cm counter += 1, saturating at MAX_DIST.
    - Echo fall: RAW=cm counter (truncating division), NO_ECHO=0, VALID -> COOLDOWN.
    - Echo still high after TIMEOUT_CYCLES: RAW=MAX_DIST, NO_ECHO=1, VALID -> COOLDOWN.
  - COOLDOWN: wait COOLDOWN_CYCLES -> IDLE, BUSY=0 in the same cycle as the IDLE entry.
- START outside IDLE is ignored, not queued.
- START on the cycle reset releases is honoured.
- Filter:
  - On each completion, shift the raw value into a 3-entry history and output the median.
  - DISTANCE_DEBOUNCED and DISTANCE_RAW update in the same cycle as VALID. Results are not registered twice.
  - Timeout results enter the history as MAX_DIST.
- Counter widths:
  - State-duration counter is 21 bits, sized for max(TIMEOUT, COOLDOWN).
  - Sub-counter is 13 bits; cm counter is 8 bits.
  - All counters are unsigned; no wrap beyond saturation.

Decomposition:
- Shared package us_pkg holds:
  - State encoding constants: IDLE, PRE_LOW, TRIG, POST_LOW, HOLDOFF, WAIT_RISE, MEASURE, COOLDOWN.
  - DIST_W=8, MAX_DIST, and the default timing constants; the other ranger instances and the sensor-processing stage use the same constants.
- One sub-module, us_median3: three 8-bit inputs, combinational median via three compares, 8-bit output. The history registers stay in us_ping_ranger.

Test Plan (bench overrides: TRIG_CYCLES=5, HOLDOFF_CYCLES=10, CYC_PER_CM=10, TIMEOUT_CYCLES=3000, COOLDOWN_CYCLES=20; sensor model on SIG):
- Trigger waveform: START pulse -> SIG shows 0 for 1 cycle, 1 for 5 cycles, 0 for 1 cycle, then Z; BUSY=1 throughout.
- Normal range: echo rises 30 cycles after release, high 1000 cycles -> DISTANCE_RAW=100 (±1), NO_ECHO=0, one VALID pulse, BUSY drops 20 cycles later.
- Saturation and timeout:
  - Echo high 2900 cycles -> RAW=255 (saturated), NO_ECHO=0.
  - No echo at all -> VALID after 3000 WAIT_RISE cycles with RAW=255, NO_ECHO=1.
- Median: raw sequence 40, 200, 42 -> DISTANCE_DEBOUNCED=0, 40, 42 after each VALID.
- Robustness:
  - START held high through a whole cycle -> exactly one measurement per IDLE entry.
  - RST_N=0 during MEASURE -> next cycle SIG=Z, BUSY=0, all outputs 0, no VALID.
- Holdoff: echo glitch 3 cycles long inside HOLDOFF, then real echo of 500 cycles -> RAW=50; glitch ignored.
